// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch, data), the arbiter and the
// single-port memory.
//   slave  : arbiter view (takes requests and mem_rdata, drives dones and mem_*)
//   master : requester/memory view (drives requests and mem_rdata)
// Fetch port : if_req, if_addr -> if_done, if_rdata, if_err
// Data port  : dm_req, dm_wr, dm_addr, dm_wdata -> dm_done, dm_rdata, dm_err
// Memory port: mem_en, mem_wr, mem_addr, mem_wdata <- mem_rdata
// Status     : busy
interface mem_arbiter_if;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [DW-1:0] if_rdata;
    logic          if_err;

    logic          dm_req;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_done;
    logic [DW-1:0] dm_rdata;
    logic          dm_err;

    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
        output if_done, if_rdata, if_err, dm_done, dm_rdata, dm_err,
               mem_en, mem_wr, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
        input  if_done, if_rdata, if_err, dm_done, dm_rdata, dm_err,
               mem_en, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// data accesses. One access in flight at a time; data wins arbitration unless
// fetch has been passed over STARVE_MAX times in a row. Misaligned winners are
// completed immediately with an error and never reach memory.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_arbiter_if.slave (fetch port, data port, memory port, busy)
// Parameters:
//   LATENCY    : mem_en cycle to valid mem_rdata, 1..15
//   STARVE_MAX : data grants allowed over a waiting fetch, 1..15
module mem_arbiter #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam int unsigned CW = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] starve_cnt;
    logic          cur_fetch;
    logic          cur_wr;

    logic          any_req_c;
    logic          fetch_wins_c;
    logic          pick_wr_c;
    logic          pick_mis_c;
    logic [AW-1:0] pick_addr_c;
    logic [DW-1:0] pick_wdata_c;

    // Winner selection for the IDLE sample; fetch only wins over a live data
    // request once the starvation limit is reached.
    always_comb begin
        any_req_c    = bus.if_req | bus.dm_req;
        fetch_wins_c = bus.if_req & (~bus.dm_req | (starve_cnt == CW'(STARVE_MAX)));
        pick_wr_c    = fetch_wins_c ? 1'b0 : bus.dm_wr;
        pick_addr_c  = fetch_wins_c ? bus.if_addr : bus.dm_addr;
        pick_wdata_c = fetch_wins_c ? '0 : bus.dm_wdata;
        pick_mis_c   = pick_addr_c[0];
    end

    // Arbiter FSM with registered outputs; pulses and mem_* default to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            starve_cnt    <= '0;
            cur_fetch     <= 1'b0;
            cur_wr        <= 1'b0;
            bus.if_done   <= 1'b0;
            bus.if_rdata  <= '0;
            bus.if_err    <= 1'b0;
            bus.dm_done   <= 1'b0;
            bus.dm_rdata  <= '0;
            bus.dm_err    <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b0;
        end else begin
            bus.if_done   <= 1'b0;
            bus.if_err    <= 1'b0;
            bus.dm_done   <= 1'b0;
            bus.dm_err    <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;

            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        cur_fetch <= fetch_wins_c;
                        cur_wr    <= pick_wr_c;
                        bus.busy  <= 1'b1;
                        // Only a data grant over a waiting fetch counts as starvation.
                        if (fetch_wins_c || !bus.if_req) begin
                            starve_cnt <= '0;
                        end else begin
                            starve_cnt <= starve_cnt + CW'(1);
                        end
                        if (pick_mis_c) begin
                            state <= DONE;
                            if (fetch_wins_c) begin
                                bus.if_done  <= 1'b1;
                                bus.if_err   <= 1'b1;
                                bus.if_rdata <= '0;
                            end else begin
                                bus.dm_done  <= 1'b1;
                                bus.dm_err   <= 1'b1;
                                bus.dm_rdata <= '0;
                            end
                        end else begin
                            state         <= ISSUE;
                            bus.mem_en    <= 1'b1;
                            bus.mem_wr    <= pick_wr_c;
                            bus.mem_addr  <= pick_addr_c;
                            bus.mem_wdata <= pick_wdata_c;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= CW'(LATENCY);
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    // cnt == 1 is exactly LATENCY cycles after the mem_en cycle.
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        if (cur_fetch) begin
                            bus.if_done  <= 1'b1;
                            bus.if_rdata <= bus.mem_rdata;
                        end else begin
                            bus.dm_done  <= 1'b1;
                            bus.dm_rdata <= cur_wr ? '0 : bus.mem_rdata;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single-port memory between the fetch stage (instruction reads) and the memory stage (data reads/writes), so the processor runs on one unified memory. It accepts one request at a time and issues it to a fixed-latency memory. It completes each request to its requester with a one-cycle done pulse. Data requests have priority, and a starvation guard bounds how long fetch can be locked out.

## Interface
- LATENCY, 2: cycles from the memory enable cycle to valid `mem_rdata`; legal range 1..15.
- STARVE_MAX, 3: consecutive data grants allowed while fetch is waiting before fetch is forced to win; legal range 1..15.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until `if_done`.
- if_addr  in  16  fetch byte address; stable while `if_req` is high.
- if_done  out  1  one-cycle fetch completion pulse.
- if_rdata  out  16  instruction word; valid in the `if_done` cycle and held until the next `if_done`.
- if_err  out  1  qualifies `if_done`; high means the address was misaligned.
- dm_req  in  1  data request; held high until `dm_done`.
- dm_wr  in  1  1 = write, 0 = read; stable with `dm_req`.
- dm_addr  in  16  data byte address.
- dm_wdata  in  16  write data.
- dm_done  out  1  one-cycle data completion pulse.
- dm_rdata  out  16  read data (0 for writes); valid in the `dm_done` cycle and held until the next `dm_done`.
- dm_err  out  1  qualifies `dm_done`; high means the address was misaligned.
- mem_en  out  1  memory access strobe, exactly one cycle per access.
- mem_wr  out  1  write select, valid with `mem_en`.
- mem_addr  out  16  memory address, valid with `mem_en`.
- mem_wdata  out  16  memory write data, valid with `mem_en`.
- mem_rdata  in  16  memory read data, valid LATENCY cycles after the `mem_en` cycle.
- busy  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE.
- **IDLE:** sample requests.
  - Neither request high: stay in IDLE.
  - Otherwise pick a winner and latch its address, write select, write data and identity.
- **Priority:**
  - `dm_req` wins over `if_req`.
  - Exception: `starve_cnt == STARVE_MAX` and both requests high; then fetch wins.
- **Starvation counter `starve_cnt`** (4 bits):
  - Increments on a data grant made while `if_req` is high.
  - Clears on a fetch grant.
  - Clears on a data grant made while `if_req` is low.
- **Misaligned winner** (`addr[0] == 1`): go directly IDLE -> DONE.
  - No `mem_en` is issued.
  - Done pulse with err=1 and rdata=0.
- **ISSUE:**
  - `mem_en = 1`; `mem_wr`, `mem_addr` and `mem_wdata` come from the latched request.
  - Load `cnt = LATENCY`; go to WAIT.
- **WAIT:**
  - `cnt` decrements each cycle.
  - In the cycle `cnt == 1`, capture `mem_rdata` into the winner's rdata register (capture 0 for writes); go to DONE.
- **DONE:**
  - Assert the winner's done for exactly one cycle, with err=0 (or err=1 on the misaligned path).
  - Return to IDLE.
  - Requests are not sampled in DONE.
- **Requester contract:**
  - After seeing done, a requester drops its request in the next cycle, or keeps it high with a new address to make a new request.
  - The arbiter samples again in the cycle after DONE.
- The losing requester's inputs are ignored; its request simply remains pending.
- The outputs `mem_*` are 0 whenever `mem_en` is 0.

## Timing
- **Latency:** a request sampled in IDLE at cycle T gives ISSUE (`mem_en`) at T+1, capture at T+1+LATENCY, and done at T+2+LATENCY.
- **Misaligned request:** done at T+1.
- **Back-to-back:** a new access to the same requester is sampled at D+1 (D = done cycle), so throughput is one access per LATENCY+3 cycles.
- **Done is exclusive:** `if_done` and `dm_done` are never high in the same cycle.
- **Reset mid-operation:**
  - Any in-flight access is abandoned and no done is generated.
  - State returns to IDLE; the first sample happens on the first edge after `rst` falls.
- **Reset values:**
  - State IDLE; `cnt` = 0; `starve_cnt` = 0.
  - `if_done`, `dm_done`, `if_err`, `dm_err`, `mem_en`, `mem_wr`, `busy` = 0.
  - `if_rdata`, `dm_rdata`, `mem_addr`, `mem_wdata` = 0.

## Test plan
- **Lone fetch** (LATENCY=2): `if_req` with `if_addr=0x0010`, memory word 0x1234 -> `mem_en` one cycle later with `mem_addr=0x0010`; `if_done` 4 cycles after the sample cycle with `if_rdata=0x1234` and `if_err=0`; `dm_done` stays 0.
- **Data write then read:** write `dm_addr=0x0100`, `dm_wdata=0xBEEF` -> `mem_wr=1` with the `mem_en` pulse, then `dm_done` with `dm_rdata=0`. Follow with a read of 0x0100 -> `dm_rdata=0xBEEF`.
- **Collision and starvation** (STARVE_MAX=3): `if_req` and `dm_req` held high continuously -> grant order data, data, data, fetch, data, data, data, fetch; exactly one done per access.
- **Misaligned requests:** `dm_addr=0x0003` -> `dm_done` with `dm_err=1` one cycle after sampling and no `mem_en`. Same check with `if_addr=0x0001` on the fetch port.
- **Reset mid-operation:** assert `rst` in a WAIT cycle -> all outputs 0 immediately and no done ever follows. Re-request after reset -> normal completion with the normal latency.
- **LATENCY=1 build:** a single access completes at T+3, and the captured data matches `mem_rdata` in the capture cycle.
